bus_ctrl: RTL and testbench

//  Memory/IO bus controller directly downstream of the 6502 core bus (addr/rw/data_o -> data_i/ready).

---
 rtl/bus_ctrl.sv | 151 +++++++++++++++
 tb/tb_bus_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_ctrl.sv
// rtl/bus_ctrl.sv - 6502 bus controller: RAM/ROM/IO decode, posted IO write FIFO, IO read stall with timeout
module bus_ctrl #(
  parameter int         RAM_AW      = 15,
  parameter int         ROM_AW      = 14,
  parameter logic [3:0] IO_HI       = 4'h8,
  parameter int         WFIFO_DEPTH = 4,
  parameter int         IO_TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       cpu_addr,
  input  logic              cpu_rw,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_rdata,
  output logic              io_req,
  output logic              io_we,
  output logic [11:0]       io_addr,
  output logic [7:0]        io_wdata,
  input  logic [7:0]        io_rdata,
  input  logic              io_ack,
  output logic              err_timeout,
  output logic              err_wovf,
  input  logic              err_clr
);

  localparam int FAW = $clog2(WFIFO_DEPTH);
  localparam logic [7:0] TMO_LAST = 8'(IO_TIMEOUT - 1);

  typedef enum logic [1:0] {REG_UNM, REG_RAM, REG_ROM, REG_IO} region_t;
  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;

  region_t     dec, region_r;
  state_t      state, state_nx;
  logic        rd_pending, accept, io_push, io_rd_start, push_ok, pop, tmo, full, empty;
  logic [7:0]  rd_buf, tmo_cnt;
  logic [11:0] rd_addr;
  logic [19:0] fifo_mem [WFIFO_DEPTH];
  logic [19:0] head;
  logic [FAW-1:0] wr_ptr, rd_ptr;
  logic [FAW:0]   count;

  // Lower regions win when windows overlap.
  always_comb begin
    dec = REG_UNM;
    if ((cpu_addr >> RAM_AW) == 16'd0)                 dec = REG_RAM;
    else if ((cpu_addr >> ROM_AW) == (16'hFFFF >> ROM_AW)) dec = REG_ROM;
    else if (cpu_addr[15:12] == IO_HI)                 dec = REG_IO;
  end

  assign accept      = ~rd_pending;
  assign ram_we      = accept & (dec == REG_RAM) & ~cpu_rw & ~rst;
  assign io_push     = accept & (dec == REG_IO) & ~cpu_rw;
  assign io_rd_start = accept & (dec == REG_IO) & cpu_rw;
  assign ram_addr    = cpu_addr[RAM_AW-1:0];
  assign ram_wdata   = cpu_wdata;
  assign rom_addr    = cpu_addr[ROM_AW-1:0];
  assign cpu_ready   = ~rd_pending;

  always_comb begin
    case (region_r)
      REG_RAM: cpu_rdata = ram_rdata;
      REG_ROM: cpu_rdata = rom_rdata;
      REG_IO:  cpu_rdata = rd_buf;
      default: cpu_rdata = 8'hFF;
    endcase
  end

  assign full    = (count == (FAW+1)'(WFIFO_DEPTH));
  assign empty   = (count == '0);
  assign tmo     = (state != S_IDLE) & ~io_ack & (tmo_cnt == TMO_LAST);
  assign pop     = (state == S_WR) & (io_ack | tmo);
  // A full FIFO still takes the write when the head leaves on the same edge.
  assign push_ok = io_push & (~full | pop);
  assign head    = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= {cpu_addr[11:0], cpu_wdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + (FAW+1)'(push_ok) - (FAW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (!empty)          state_nx = S_WR;
        else if (rd_pending) state_nx = S_RD;
      end
      S_WR, S_RD: if (io_ack || tmo) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign io_req   = (state != S_IDLE);
  assign io_we    = (state == S_WR);
  assign io_addr  = (state == S_RD) ? rd_addr : head[19:8];
  assign io_wdata = head[7:0];

  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE) tmo_cnt <= '0;
    else                        tmo_cnt <= tmo_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pending  <= 1'b0;
      rd_buf      <= 8'hFF;
      rd_addr     <= '0;
      region_r    <= REG_UNM;
      err_timeout <= 1'b0;
      err_wovf    <= 1'b0;
    end else begin
      if (accept) region_r <= dec;
      if (io_rd_start) begin
        rd_pending <= 1'b1;
        rd_addr    <= cpu_addr[11:0];
      end else if (state == S_RD && (io_ack || tmo)) begin
        rd_pending <= 1'b0;
        rd_buf     <= io_ack ? io_rdata : 8'hFF;
      end
      // Set events take priority over a simultaneous clear.
      if (tmo)                         err_timeout <= 1'b1;
      else if (err_clr)                err_timeout <= 1'b0;
      if (io_push && full && !pop)     err_wovf    <= 1'b1;
      else if (err_clr)                err_wovf    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_ctrl.sv
// tb/tb_bus_ctrl.sv - scoreboard bench for bus_ctrl with RAM/ROM/IO device models
module tb_bus_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [13:0] rom_addr;
  logic [7:0]  rom_rdata;
  logic        io_req, io_we;
  logic [11:0] io_addr;
  logic [7:0]  io_wdata, io_rdata;
  logic        io_ack;
  logic        err_timeout, err_wovf, err_clr;

  int checks = 0;
  int failures = 0;
  int ack_delay = -1;
  int req_cycles = 0;
  int req_run = 0;
  int last_req_len = 0;
  logic force_ack = 1'b0;
  logic last_we;
  logic [7:0]  sb [$];
  logic [20:0] io_log [$];
  logic [7:0]  mem [0:32767];

  bus_ctrl dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .io_ack(io_ack), .err_timeout(err_timeout), .err_wovf(err_wovf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
    rom_rdata <= rom_addr[7:0] ^ 8'hC8;
  end

  always @(posedge clk) begin
    if (io_req && io_ack) io_log.push_back({io_we, io_addr, io_wdata});
    if (io_req) req_run++;
    else if (req_run > 0) begin
      last_req_len = req_run;
      req_run = 0;
    end
  end

  always @(negedge clk) begin
    if (io_req && !rst) begin
      io_ack = (ack_delay >= 0) && (req_cycles >= ack_delay);
      req_cycles++;
    end else begin
      io_ack = force_ack;
      req_cycles = 0;
    end
    io_rdata = io_addr[7:0] ^ 8'h3C;
  end

  task automatic cpu_op(input logic [15:0] a, input logic rw, input logic [7:0] d,
                        input logic [7:0] exp, input int exp_stall);
    int stalls;
    logic [7:0] want;
    cpu_addr = a; cpu_rw = rw; cpu_wdata = d;
    if (rw) sb.push_back(exp);
    #1 last_we = ram_we;
    @(negedge clk);
    if (rw) begin
      stalls = 0;
      while (!cpu_ready && stalls < 1000) begin
        stalls++;
        @(negedge clk);
      end
      want = sb.pop_front();
      checks++;
      if (!cpu_ready || cpu_rdata !== want) begin
        failures++;
        $display("FAIL read_%h rdata=%h ready=%b exp=%h", a, cpu_rdata, cpu_ready, want);
      end
      if (exp_stall >= 0) begin
        checks++;
        if (stalls != exp_stall) begin
          failures++;
          $display("FAIL stall_%h got=%0d exp=%0d", a, stalls, exp_stall);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    cpu_addr = 16'hA000; cpu_rw = 1'b0; cpu_wdata = 8'h00;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; err_clr = 1'b0;
    cpu_addr = 16'h0100; cpu_rw = 1'b0; cpu_wdata = 8'hEE;
    repeat (3) @(negedge clk);
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL rst_ram_we got=%b exp=0", ram_we); end
    checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", cpu_ready); end
    checks++; if (cpu_rdata !== 8'hFF) begin failures++; $display("FAIL rst_rdata got=%h exp=ff", cpu_rdata); end
    checks++; if (io_req !== 1'b0) begin failures++; $display("FAIL rst_io_req got=%b exp=0", io_req); end
    checks++; if ({err_timeout, err_wovf} !== 2'b00) begin failures++; $display("FAIL rst_err got=%b exp=00", {err_timeout, err_wovf}); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_ram;
    cpu_op(16'h0200, 1'b0, 8'h5A, 8'h00, -1);
    checks++; if (last_we !== 1'b1) begin failures++; $display("FAIL ram_we_write got=%b exp=1", last_we); end
    cpu_op(16'h0200, 1'b1, 8'h00, 8'h5A, 0);
    checks++; if (last_we !== 1'b0) begin failures++; $display("FAIL ram_we_read got=%b exp=0", last_we); end
    cpu_op(16'h7FFF, 1'b0, 8'hC3, 8'h00, -1);
    cpu_op(16'h7FFF, 1'b1, 8'h00, 8'hC3, 0);
    cpu_op(16'h0200, 1'b1, 8'h00, 8'h5A, 0);
    idle(1);
  endtask

  task automatic test_rom_unmapped;
    int n;
    n = io_log.size();
    cpu_op(16'hFFFC, 1'b1, 8'h00, 8'h34, 0);
    cpu_op(16'hC000, 1'b1, 8'h00, 8'hC8, 0);
    cpu_op(16'hC000, 1'b0, 8'h99, 8'h00, -1);
    checks++; if (last_we !== 1'b0) begin failures++; $display("FAIL rom_write_we got=%b exp=0", last_we); end
    cpu_op(16'h9123, 1'b1, 8'h00, 8'hFF, 0);
    cpu_op(16'hA000, 1'b0, 8'h11, 8'h00, -1);
    idle(3);
    checks++; if (io_req !== 1'b0 || io_log.size() != n || err_wovf !== 1'b0) begin
      failures++; $display("FAIL no_io_activity io_req=%b log=%0d exp_log=%0d", io_req, io_log.size(), n);
    end
  endtask

  task automatic test_io_order;
    int n;
    n = io_log.size();
    ack_delay = 3;
    cpu_op(16'h8003, 1'b0, 8'h77, 8'h00, -1);
    cpu_op(16'h8010, 1'b1, 8'h00, 8'h10 ^ 8'h3C, 9);
    idle(2);
    checks++; if (io_log.size() != n + 2) begin
      failures++; $display("FAIL io_order_count got=%0d exp=%0d", io_log.size(), n + 2);
    end else begin
      checks++; if (io_log[n] !== {1'b1, 12'h003, 8'h77}) begin
        failures++; $display("FAIL io_order_first got=%h exp=%h", io_log[n], {1'b1, 12'h003, 8'h77});
      end
      checks++; if (io_log[n+1][20:8] !== {1'b0, 12'h010}) begin
        failures++; $display("FAIL io_order_second got=%h exp=%h", io_log[n+1][20:8], {1'b0, 12'h010});
      end
    end
  endtask

  task automatic test_read_latency;
    ack_delay = 0;
    cpu_op(16'h8020, 1'b1, 8'h00, 8'h20 ^ 8'h3C, 2);
    cpu_op(16'h0200, 1'b1, 8'h00, 8'h5A, 0);
    idle(2);
  endtask

  task automatic test_wovf;
    int n, w;
    n = io_log.size();
    ack_delay = -1;
    for (int i = 0; i < 5; i++) begin
      cpu_op(16'h8040 + 16'(i), 1'b0, 8'(8'hB0 + i), 8'h00, -1);
      if (i == 3) begin
        checks++; if (err_wovf !== 1'b0) begin failures++; $display("FAIL wovf_early got=%b exp=0", err_wovf); end
      end
    end
    idle(1);
    checks++; if (err_wovf !== 1'b1) begin failures++; $display("FAIL wovf_set got=%b exp=1", err_wovf); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (err_wovf !== 1'b0) begin failures++; $display("FAIL wovf_clr got=%b exp=0", err_wovf); end
    ack_delay = 0;
    w = 0;
    while (io_log.size() < n + 4 && w < 100) begin w++; @(negedge clk); end
    idle(10);
    checks++; if (io_log.size() != n + 4) begin
      failures++; $display("FAIL wovf_drain got=%0d exp=%0d", io_log.size(), n + 4);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (io_log[n+i] !== {1'b1, 12'h040 + 12'(i), 8'(8'hB0 + i)}) begin
          failures++; $display("FAIL wovf_entry%0d got=%h exp=%h", i, io_log[n+i], {1'b1, 12'h040 + 12'(i), 8'(8'hB0 + i)});
        end
      end
    end
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL wovf_no_tmo got=%b exp=0", err_timeout); end
  endtask

  task automatic test_timeout;
    ack_delay = -1;
    cpu_op(16'h8055, 1'b1, 8'h00, 8'hFF, 256);
    idle(3);
    checks++; if (last_req_len != 255) begin failures++; $display("FAIL tmo_req_len got=%0d exp=255", last_req_len); end
    checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL tmo_err got=%b exp=1", err_timeout); end
    checks++; if (cpu_ready !== 1'b1 || io_req !== 1'b0) begin
      failures++; $display("FAIL tmo_resume ready=%b io_req=%b exp=1/0", cpu_ready, io_req);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL tmo_clr got=%b exp=0", err_timeout); end
  endtask

  task automatic test_reset_mid;
    int n, w;
    ack_delay = -1;
    cpu_addr = 16'h8066; cpu_rw = 1'b1; cpu_wdata = 8'h00;
    w = 0;
    @(negedge clk);
    while (!io_req && w < 20) begin w++; @(negedge clk); end
    checks++; if (io_req !== 1'b1) begin failures++; $display("FAIL mid_req_start got=%b exp=1", io_req); end
    n = io_log.size();
    rst = 1'b1;
    cpu_addr = 16'hA000; cpu_rw = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (io_req !== 1'b0 || cpu_ready !== 1'b1 || cpu_rdata !== 8'hFF) begin
      failures++; $display("FAIL mid_rst io_req=%b ready=%b rdata=%h exp=0/1/ff", io_req, cpu_ready, cpu_rdata);
    end
    ack_delay = 0;
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;
    idle(3);
    checks++; if (io_req !== 1'b0 || io_log.size() != n || err_timeout !== 1'b0 || cpu_ready !== 1'b1) begin
      failures++; $display("FAIL mid_late_ack io_req=%b log=%0d exp_log=%0d ready=%b", io_req, io_log.size(), n, cpu_ready);
    end
    cpu_op(16'hFFFC, 1'b1, 8'h00, 8'h34, 0);
    idle(1);
  endtask

  initial begin
    test_reset;
    test_ram;
    test_rom_unmapped;
    test_io_order;
    test_read_latency;
    test_wovf;
    test_timeout;
    test_reset_mid;
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_empty got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
